// File: rtl/wb_uart_fanout_pkg.sv
// Shared types, local register map and helpers for the Wishbone UART fan-out.
package wb_uart_fanout_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Offsets inside the local register block
   localparam int unsigned REG_INT_MASK      = 32'd0;
   localparam int unsigned REG_INT_STATUS    = 32'd1;
   localparam int unsigned REG_TIMEOUT_COUNT = 32'd2;

   // Width of the saturating timeout event counter
   localparam int TO_CNT_W = 8;

   // Ceiling log2 with a floor of 1 bit, usable in parameter expressions
   function automatic int clog2(input int value);
      int res;
      res = 1;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            res = i + 1;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_uart_fanout_if.sv
// Master-side Wishbone bus bundle feeding the fan-out.
interface wb_uart_fanout_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                      wb_cyc_i;
   logic                      wb_stb_i;
   logic                      wb_we_i;
   logic [31:0]               wb_adr_i;
   logic [DATA_WIDTH/8-1:0]   wb_sel_i;
   logic [DATA_WIDTH-1:0]     wb_dat_i;
   logic [DATA_WIDTH-1:0]     wb_dat_o;
   logic                      wb_ack_o;
   logic                      wb_err_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/wb_uart_fanout_watchdog.sv
// Cycle timer that flags expiry once it has counted TIMEOUT_CYCLES-1 steps.
module wb_uart_fanout_watchdog
   import wb_uart_fanout_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int TW = clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] tmr_q;
   logic [TW-1:0] tmr_d;

   // Next timer value: clear has priority over counting
   always_comb begin
      tmr_d = tmr_q;
      if (clr_i) begin
         tmr_d = {TW{1'b0}};
      end else if (en_i) begin
         tmr_d = tmr_q + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         tmr_d = tmr_q;
      end
   end

   // Timer register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmr_q <= {TW{1'b0}};
      end else begin
         tmr_q <= tmr_d;
      end
   end

   assign expire_o = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_uart_fanout.sv
// Wishbone fan-out to NUM_CHANNELS UART channels with a local register bank,
// per-access timeout and masked interrupt aggregation.
module wb_uart_fanout
   import wb_uart_fanout_pkg::*;
#(
   parameter int NUM_CHANNELS   = 4,
   parameter int CH_ADDR_BITS   = 3,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_n_i,
   wb_uart_fanout_if.slave                    wb,
   output logic [NUM_CHANNELS-1:0]            ch_cyc_o,
   output logic [NUM_CHANNELS-1:0]            ch_stb_o,
   output logic                               ch_we_o,
   output logic [CH_ADDR_BITS-1:0]            ch_adr_o,
   output logic [DATA_WIDTH/8-1:0]            ch_sel_o,
   output logic [DATA_WIDTH-1:0]              ch_dat_o,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_dat_i,
   input  logic [NUM_CHANNELS-1:0]            ch_ack_i,
   input  logic [NUM_CHANNELS-1:0]            ch_int_i,
   output logic                               int_o
);
   localparam int CHW = clog2(NUM_CHANNELS + 1);
   localparam int SW  = DATA_WIDTH / 8;

   state_e                  state_q, state_d;
   logic [CHW-1:0]          idx_q, idx_d;
   logic [NUM_CHANNELS-1:0] ch_req_q, ch_req_d;
   logic                    ch_we_q, ch_we_d;
   logic [CH_ADDR_BITS-1:0] ch_adr_q, ch_adr_d;
   logic [SW-1:0]           ch_sel_q, ch_sel_d;
   logic [DATA_WIDTH-1:0]   ch_dat_q, ch_dat_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic [NUM_CHANNELS-1:0] mask_q, mask_d;
   logic [TO_CNT_W-1:0]     to_cnt_q, to_cnt_d;
   logic                    int_q;

   logic [CHW-1:0]          req_idx_s;
   logic [CH_ADDR_BITS-1:0] loc_off_s;
   logic                    ack_sel_s;
   logic [DATA_WIDTH-1:0]   ch_rdata_s;
   logic [NUM_CHANNELS-1:0] onehot_s;
   logic [DATA_WIDTH-1:0]   loc_rdata_s;
   logic                    tmr_clr_s, tmr_en_s, tmr_expire_s;
   logic                    unused_s;

   assign req_idx_s = wb.wb_adr_i[CH_ADDR_BITS +: CHW];
   assign loc_off_s = wb.wb_adr_i[CH_ADDR_BITS-1:0];
   // Address bits above the channel index are deliberately ignored
   assign unused_s  = ^wb.wb_adr_i[31:CH_ADDR_BITS+CHW];

   wb_uart_fanout_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i   (wb_clk_i),
      .rst_n_i (wb_rst_n_i),
      .clr_i   (tmr_clr_s),
      .en_i    (tmr_en_s),
      .expire_o(tmr_expire_s)
   );

   // Select the active channel's ack/data and build the one-hot request strobe
   always_comb begin
      ack_sel_s  = 1'b0;
      ch_rdata_s = {DATA_WIDTH{1'b0}};
      onehot_s   = {NUM_CHANNELS{1'b0}};
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         if (idx_q == CHW'(k)) begin
            ack_sel_s  = ch_ack_i[k];
            ch_rdata_s = ch_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
         end else begin
         end
         if (req_idx_s == CHW'(k)) begin
            onehot_s[k] = 1'b1;
         end else begin
         end
      end
   end

   // Local register read mux; unmapped offsets read as zero
   always_comb begin
      loc_rdata_s = {DATA_WIDTH{1'b0}};
      case (loc_off_s)
         CH_ADDR_BITS'(REG_INT_MASK):      loc_rdata_s = DATA_WIDTH'(mask_q);
         CH_ADDR_BITS'(REG_INT_STATUS):    loc_rdata_s = DATA_WIDTH'(ch_int_i);
         CH_ADDR_BITS'(REG_TIMEOUT_COUNT): loc_rdata_s = DATA_WIDTH'(to_cnt_q);
         default:                          loc_rdata_s = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Access FSM: decode, forward/local/error, one-cycle termination
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ch_req_d  = ch_req_q;
      ch_we_d   = ch_we_q;
      ch_adr_d  = ch_adr_q;
      ch_sel_d  = ch_sel_q;
      ch_dat_d  = ch_dat_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_d     = dat_q;
      mask_d    = mask_q;
      to_cnt_d  = to_cnt_q;
      tmr_clr_s = 1'b0;
      tmr_en_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wb.wb_cyc_i && wb.wb_stb_i) begin
               if (req_idx_s < CHW'(NUM_CHANNELS)) begin
                  state_d   = ST_FWD;
                  idx_d     = req_idx_s;
                  ch_req_d  = onehot_s;
                  ch_we_d   = wb.wb_we_i;
                  ch_adr_d  = loc_off_s;
                  ch_sel_d  = wb.wb_sel_i;
                  ch_dat_d  = wb.wb_dat_i;
                  tmr_clr_s = 1'b1;
               end else if (req_idx_s == CHW'(NUM_CHANNELS)) begin
                  state_d = ST_RESP;
                  ack_d   = 1'b1;
                  dat_d   = loc_rdata_s;
                  if (wb.wb_we_i && wb.wb_sel_i[0]) begin
                     if (loc_off_s == CH_ADDR_BITS'(REG_INT_MASK)) begin
                        mask_d = wb.wb_dat_i[NUM_CHANNELS-1:0];
                     end else if (loc_off_s == CH_ADDR_BITS'(REG_TIMEOUT_COUNT)) begin
                        to_cnt_d = {TO_CNT_W{1'b0}};
                     end else begin
                     end
                  end else begin
                  end
               end else begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  dat_d   = {DATA_WIDTH{1'b0}};
               end
            end else begin
            end
         end
         ST_FWD: begin
            if (!wb.wb_cyc_i) begin
               // Master abandoned the cycle: release the channel silently
               ch_req_d = {NUM_CHANNELS{1'b0}};
               state_d  = ST_IDLE;
            end else if (ack_sel_s) begin
               ch_req_d = {NUM_CHANNELS{1'b0}};
               dat_d    = ch_rdata_s;
               ack_d    = 1'b1;
               state_d  = ST_RESP;
            end else if (tmr_expire_s) begin
               ch_req_d = {NUM_CHANNELS{1'b0}};
               dat_d    = {DATA_WIDTH{1'b0}};
               err_d    = 1'b1;
               state_d  = ST_RESP;
               if (to_cnt_q != {TO_CNT_W{1'b1}}) begin
                  to_cnt_d = to_cnt_q + {{(TO_CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  to_cnt_d = to_cnt_q;
               end
            end else begin
               tmr_en_s = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            ch_req_d = {NUM_CHANNELS{1'b0}};
         end
      endcase
   end

   // State, channel-side, response and local register storage
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q  <= ST_IDLE;
         idx_q    <= {CHW{1'b0}};
         ch_req_q <= {NUM_CHANNELS{1'b0}};
         ch_we_q  <= 1'b0;
         ch_adr_q <= {CH_ADDR_BITS{1'b0}};
         ch_sel_q <= {SW{1'b0}};
         ch_dat_q <= {DATA_WIDTH{1'b0}};
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= {DATA_WIDTH{1'b0}};
         mask_q   <= {NUM_CHANNELS{1'b0}};
         to_cnt_q <= {TO_CNT_W{1'b0}};
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ch_req_q <= ch_req_d;
         ch_we_q  <= ch_we_d;
         ch_adr_q <= ch_adr_d;
         ch_sel_q <= ch_sel_d;
         ch_dat_q <= ch_dat_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
         mask_q   <= mask_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Registered masked interrupt aggregate
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         int_q <= 1'b0;
      end else begin
         int_q <= |(ch_int_i & mask_q);
      end
   end

   assign ch_cyc_o    = ch_req_q;
   assign ch_stb_o    = ch_req_q;
   assign ch_we_o     = ch_we_q;
   assign ch_adr_o    = ch_adr_q;
   assign ch_sel_o    = ch_sel_q;
   assign ch_dat_o    = ch_dat_q;
   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_dat_o = dat_q;
   assign int_o       = int_q;

endmodule
